// File: rtl/mul_add_issue.sv
// Issue/retire wrapper around the registered a*b+c multiply-add macro: accepts ops,
// folds signed correction into c, tracks ops through the macro and buffers results in order.
module mul_add_issue #(
  parameter int BITS      = 64,
  parameter int MACRO_LAT = 1,
  parameter int OUT_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BITS-1:0]   in_a,
  input  logic [BITS-1:0]   in_b,
  input  logic [2*BITS-1:0] in_c,
  input  logic              in_signed,
  input  logic              in_hi,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [BITS-1:0]   mul_a,
  output logic [BITS-1:0]   mul_b,
  output logic [2*BITS-1:0] mul_c,
  input  logic [2*BITS-1:0] mul_o,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BITS-1:0]   out_data,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int PIPE = MACRO_LAT + 1;
  localparam int PW   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW   = $clog2(OUT_DEPTH + 1);
  localparam int SW   = $clog2(OUT_DEPTH + PIPE + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(OUT_DEPTH - 1);

  logic accept, push, pop;
  logic [SW-1:0] inflight;

  logic [2*BITS-1:0] corr_a, corr_b, c_adj;
  logic [BITS-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [2*BITS-1:0] mul_c_q, mul_c_d;

  logic [PIPE-1:0]   pv_q, pv_d, ph_q, ph_d;
  logic [TAG_W-1:0]  ptag_q [PIPE];
  logic [TAG_W-1:0]  ptag_d [PIPE];

  logic [BITS-1:0]   mem_data_q [OUT_DEPTH];
  logic [TAG_W-1:0]  mem_tag_q  [OUT_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [BITS-1:0]   wr_data;

  // Every in-flight op already owns a FIFO slot, so the FIFO can never overflow.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < PIPE; i++) inflight = inflight + SW'(pv_q[i]);
  end

  assign in_ready = rst_n & ((inflight + SW'(count_q)) < SW'(OUT_DEPTH));
  assign accept   = in_valid & in_ready;

  // Unsigned product of two's-complement operands is off by a<<BITS / b<<BITS when negative.
  assign corr_a = in_a[BITS-1] ? {in_b, {BITS{1'b0}}} : '0;
  assign corr_b = in_b[BITS-1] ? {in_a, {BITS{1'b0}}} : '0;
  assign c_adj  = in_signed ? (in_c - corr_a - corr_b) : in_c;

  assign mul_a_d = accept ? in_a  : mul_a_q;
  assign mul_b_d = accept ? in_b  : mul_b_q;
  assign mul_c_d = accept ? c_adj : mul_c_q;

  assign pv_d = {pv_q[PIPE-2:0], accept};
  assign ph_d = {ph_q[PIPE-2:0], in_hi};
  always_comb begin
    ptag_d[0] = in_tag;
    for (int i = 1; i < PIPE; i++) ptag_d[i] = ptag_q[i-1];
  end

  assign push    = pv_q[PIPE-1];
  assign wr_data = ph_q[PIPE-1] ? mul_o[2*BITS-1:BITS] : mul_o[BITS-1:0];
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;

  assign wr_ptr_d = !push ? wr_ptr_q : ((wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1));
  assign rd_ptr_d = !pop  ? rd_ptr_q : ((rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1));

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      mul_c_q  <= '0;
      pv_q     <= '0;
      ph_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < PIPE; i++) ptag_q[i] <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_tag_q[i]  <= '0;
      end
    end else begin
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      mul_c_q  <= mul_c_d;
      pv_q     <= pv_d;
      ph_q     <= ph_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < PIPE; i++) ptag_q[i] <= ptag_d[i];
      if (push) begin
        mem_data_q[wr_ptr_q] <= wr_data;
        mem_tag_q[wr_ptr_q]  <= ptag_q[PIPE-1];
      end
    end
  end

  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;
  assign mul_c    = mul_c_q;
  assign out_data = mem_data_q[rd_ptr_q];
  assign out_tag  = mem_tag_q[rd_ptr_q];

endmodule

// File: tb/tb_mul_add_issue.sv
// Bench for mul_add_issue: models the one-cycle multiply-add macro and scores every
// result against a full-width reference computed at accept time.
module tb_mul_add_issue;

  logic          clk;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [63:0]   in_a, in_b;
  logic [127:0]  in_c;
  logic          in_signed, in_hi;
  logic [3:0]    in_tag;
  logic [63:0]   mul_a, mul_b;
  logic [127:0]  mul_c, mul_o;
  logic          out_valid, out_ready;
  logic [63:0]   out_data;
  logic [3:0]    out_tag;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [67:0] exp_q[$];
  logic [63:0] got_data[$];
  logic [3:0]  got_tag[$];
  int          got_cyc[$];

  mul_add_issue #(.BITS(64), .MACRO_LAT(1), .OUT_DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .in_signed(in_signed), .in_hi(in_hi), .in_tag(in_tag),
    .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_o(mul_o),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Macro model: registered once, no reset.
  always @(posedge clk) mul_o <= {64'b0, mul_a} * {64'b0, mul_b} + mul_c;

  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic [127:0] c, input logic s, input logic hi);
    logic [127:0] r;
    if (s) r = {{64{a[63]}}, a} * {{64{b[63]}}, b} + c;
    else   r = {64'b0, a} * {64'b0, b} + c;
    return hi ? r[127:64] : r[63:0];
  endfunction

  // Scoreboard: push at the negedge preceding an accept edge, pop before a pop edge.
  always @(negedge clk) begin
    logic [67:0] e;
    if (rst_n === 1'b1) begin
      if (in_valid === 1'b1 && in_ready === 1'b1)
        exp_q.push_back({model(in_a, in_b, in_c, in_signed, in_hi), in_tag});
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got data=%h tag=%h, required no output", out_data, out_tag);
        end else begin
          e = exp_q.pop_front();
          if ({out_data, out_tag} !== e) begin
            n_fail++;
            $display("FAIL sb_result: got data=%h tag=%h, required data=%h tag=%h",
                     out_data, out_tag, e[67:4], e[3:0]);
          end
        end
        got_data.push_back(out_data);
        got_tag.push_back(out_tag);
        got_cyc.push_back(cyc);
      end
    end
  end

  task automatic set_op(input logic [63:0] a, input logic [63:0] b, input logic [127:0] c,
                        input logic s, input logic hi, input logic [3:0] tag);
    in_valid = 1'b1; in_a = a; in_b = b; in_c = c; in_signed = s; in_hi = hi; in_tag = tag;
  endtask

  task automatic clear_got();
    got_data.delete(); got_tag.delete(); got_cyc.delete();
  endtask

  // Holds the op until the negedge where in_ready is seen; accept lands on the next edge.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [127:0] c,
                      input logic s, input logic hi, input logic [3:0] tag);
    int t = 0;
    @(posedge clk); #1;
    set_op(a, b, c, s, hi, tag);
    @(negedge clk);
    while (in_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, t);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_c = '0; in_signed = 1'b0; in_hi = 1'b0; in_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, out_data, out_tag} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b valid=%b data=%h tag=%h, required all 0",
               in_ready, out_valid, out_data, out_tag);
    end
    n_checks++;
    if ({mul_a, mul_b, mul_c} !== '0) begin
      n_fail++;
      $display("FAIL reset_mul: got a=%h b=%h c=%h, required 0", mul_a, mul_b, mul_c);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got ready=%b valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_latency();
    clear_got();
    @(posedge clk); #1;
    out_ready = 1'b1;
    set_op(64'd3, 64'd5, 128'd7, 1'b0, 1'b0, 4'h1);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL lat_ready: got %b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== (k == 3)) begin
        n_fail++;
        $display("FAIL lat_valid_e%0d: got %b, required %b", k - 1, out_valid, (k == 3));
      end
    end
    n_checks++;
    if (out_data !== 64'd22 || out_tag !== 4'h1) begin
      n_fail++;
      $display("FAIL lat_data: got data=%0d tag=%h, required 22 1", out_data, out_tag);
    end
    wait_drain();
  endtask

  task automatic test_signed();
    clear_got();
    send(-64'sd2, 64'd3, {128{1'b1}}, 1'b1, 1'b0, 4'h2);
    send(-64'sd2, 64'd3, {128{1'b1}}, 1'b1, 1'b1, 4'h3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();
    n_checks++;
    if (got_data.size() != 2 || got_data[0] !== 64'hFFFF_FFFF_FFFF_FFF9 ||
        got_data[1] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++;
      $display("FAIL signed_halves: got %0d results lo=%h hi=%h, required lo=fffffffffffffff9 hi=ffffffffffffffff",
               got_data.size(), got_data[0], got_data[1]);
    end
  endtask

  task automatic test_wrap();
    clear_got();
    send({64{1'b1}}, {64{1'b1}}, {128{1'b1}}, 1'b0, 1'b1, 4'h4);
    send({64{1'b1}}, {64{1'b1}}, {128{1'b1}}, 1'b0, 1'b0, 4'h5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();
    n_checks++;
    if (got_data.size() != 2 || got_data[0] !== 64'hFFFF_FFFF_FFFF_FFFE || got_data[1] !== 64'h0) begin
      n_fail++;
      $display("FAIL wrap_halves: got %0d results hi=%h lo=%h, required hi=fffffffffffffffe lo=0",
               got_data.size(), got_data[0], got_data[1]);
    end
  endtask

  task automatic test_backpressure();
    int nxt = 0;
    int t = 0;
    clear_got();
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      set_op(64'(nxt + 1), 64'd3, 128'(nxt), 1'b0, 1'b0, 4'(nxt));
      @(negedge clk);
      if (in_ready === 1'b1) nxt++;
    end
    n_checks++;
    if (nxt != 4) begin
      n_fail++; $display("FAIL bp_accepted: got %0d, required 4", nxt);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_ready: got %b, required 0", in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'h0 || out_data !== 64'd3) begin
      n_fail++;
      $display("FAIL bp_head: got valid=%b tag=%h data=%0d, required 1 0 3", out_valid, out_tag, out_data);
    end
    while (nxt < 6 && t < 40) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      set_op(64'(nxt + 1), 64'd3, 128'(nxt), 1'b0, 1'b0, 4'(nxt));
      @(negedge clk);
      if (in_ready === 1'b1) nxt++;
      t++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();
    n_checks++;
    if (got_tag.size() != 6) begin
      n_fail++; $display("FAIL bp_count: got %0d results, required 6", got_tag.size());
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (got_tag[i] !== 4'(i)) begin
        n_fail++; $display("FAIL bp_order[%0d]: got tag %h, required %h", i, got_tag[i], 4'(i));
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_got();
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      set_op({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
             1'(i), 1'(i >> 1), 4'(i + 8));
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ready[%0d]: got %b, required 1", i, in_ready);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();
    n_checks++;
    if (got_cyc.size() != 8) begin
      n_fail++; $display("FAIL b2b_count: got %0d results, required 8", got_cyc.size());
    end
    for (int i = 1; i < 8; i++) begin
      n_checks++;
      if (got_cyc[i] != got_cyc[0] + i) begin
        n_fail++;
        $display("FAIL b2b_cycle[%0d]: got cycle %0d, required %0d", i, got_cyc[i], got_cyc[0] + i);
      end
    end
  endtask

  task automatic test_reset_flush();
    clear_got();
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      set_op(64'(i + 2), 64'd9, 128'd4, 1'b0, 1'b0, 4'(i + 12));
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL flush_ready[%0d]: got %b, required 1", i, in_ready);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_pre: got ready=%b valid=%b, required 0 1", in_ready, out_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || mul_a !== 64'd0) begin
      n_fail++;
      $display("FAIL flush_post: got valid=%b ready=%b mul_a=%h, required 0 1 0", out_valid, in_ready, mul_a);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    n_checks++;
    if (got_data.size() != 0) begin
      n_fail++; $display("FAIL flush_dropped: got %0d results, required 0", got_data.size());
    end
    send(64'd7, 64'd6, 128'd1, 1'b0, 1'b0, 4'hB);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();
    n_checks++;
    if (got_data.size() != 1 || got_data[0] !== 64'd43 || got_tag[0] !== 4'hB) begin
      n_fail++;
      $display("FAIL flush_next: got %0d results data=%0d tag=%h, required 1 43 b",
               got_data.size(), got_data[0], got_tag[0]);
    end
  endtask

  task automatic test_random();
    int sent = 0;
    int t = 0;
    clear_got();
    while (sent < 40 && t < 400) begin
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
      set_op({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
             1'($urandom), 1'($urandom), 4'($urandom));
      in_valid = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready === 1'b1) sent++;
      t++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    n_checks++;
    if (got_data.size() != 40) begin
      n_fail++; $display("FAIL rand_count: got %0d results, required 40", got_data.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_signed();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
